procedural_ip: RTL and testbench

Packet-capture block: accepts an AXI-Stream-style word stream, stores every received word, tagged with its packet number, in a circular RAM. It exposes that RAM and a small set of status registers through a read-only AXI-Lite slave. It sits between a data source and the host control bus, for debug and inspection of captured traffic.

---
 rtl/procedural_pkg.sv | 34 +++
 rtl/capture_ram.sv | 58 +++++
 rtl/procedural_ip.sv | 199 +++++++++++++++++++
 tb/tb_procedural_ip.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/procedural_pkg.sv
// Shared definitions for the packet-capture block.
// Holds the status-register address map, AXI-Lite response codes, the
// read-channel state encoding and the default layout of one capture entry.
// No ports: this file only declares types and constants.
package procedural_pkg;

    localparam int PKG_DW         = 32;
    localparam int PKG_INDX_WIDTH = 10;

    // Width of the per-packet word counter and of each length-history slot.
    localparam int LEN_W = 16;

    localparam int STAT_BASE   = 'h100;
    localparam int OFF_WR_PTR  = 'h0;
    localparam int OFF_PKT_IDX = 'h4;
    localparam int OFF_CUR_LEN = 'h8;
    localparam int OFF_HIST    = 'hC;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Layout of one RAM entry at the default widths: packet number on top,
    // raw stream word underneath.
    typedef struct packed {
        logic [PKG_INDX_WIDTH-1:0] idx;
        logic [PKG_DW-1:0]         data;
    } entry_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture RAM: one write port and one registered read port.
// A read and a write to the same address on the same edge return the old
// contents. A per-entry valid bit makes never-written entries read as zero
// without having to sweep the array after reset.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   wrEn_i/wrAddr_i/wrData_i   write port
//   rdEn_i/rdAddr_i     read request; rdData_o updates only when rdEn_i=1
//   rdData_o            registered read data, holds between reads
module capture_ram
    import procedural_pkg::*;
#(
    parameter int DATA_W = 42,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [DATA_W-1:0] wrData_i,
    input  logic              rdEn_i,
    input  logic [ADDR_W-1:0] rdAddr_i,
    output logic [DATA_W-1:0] rdData_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    // Storage array itself carries no reset so it can map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
    end

    // Valid bits stand in for a clear sweep: reset drops them all at once,
    // and each write marks its entry as holding real data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (wrEn_i) begin
            valid_q[wrAddr_i] <= 1'b1;
        end
    end

    // Registered read. Sampling mem and valid_q before this edge's write
    // lands is what gives read-first behaviour on an address collision.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdData_o <= '0;
        end else if (rdEn_i) begin
            rdData_o <= valid_q[rdAddr_i] ? mem[rdAddr_i] : '0;
        end
    end

endmodule

// File: rtl/procedural_ip.sv
// Packet-capture block. Every valid stream word is stored, tagged with its
// packet number, in a circular RAM; the RAM and a few status registers are
// exposed through a read-only AXI-Lite slave.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   s_tvalid, s_tlast, s_tdata   capture stream, no backpressure
//   s_axil_arvalid/araddr/arready  read-address channel (byte address)
//   s_axil_rvalid/rdata/rresp/rready  read-data channel
module procedural_ip
    import procedural_pkg::*;
#(
    parameter int DW           = 32,
    parameter int G_ADDR_WIDTH = 5,
    parameter int G_INDX_WIDTH = 10,
    parameter int G_MODS       = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    input  logic [DW-1:0]           s_tdata,
    input  logic                    s_axil_arvalid,
    input  logic [G_INDX_WIDTH-1:0] s_axil_araddr,
    output logic                    s_axil_arready,
    output logic                    s_axil_rvalid,
    output logic [31:0]             s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    input  logic                    s_axil_rready
);

    localparam int G_DW_WIRE_MEM = DW + G_INDX_WIDTH;

    logic [G_ADDR_WIDTH-1:0]       wrPtr_q, wrPtr_d;
    logic [G_INDX_WIDTH-1:0]       pktIdx_q, pktIdx_d;
    logic [LEN_W-1:0]              curLen_q, curLen_d;
    logic [G_MODS-1:0][LEN_W-1:0]  hist_q, hist_d;
    logic [LEN_W-1:0]              pktLen;

    // Next-state for the capture counters. A tlast word closes the packet:
    // its full length goes into the newest history slot, the oldest slot
    // falls off the end, and the word counter restarts for the next packet.
    always_comb begin
        wrPtr_d  = wrPtr_q;
        pktIdx_d = pktIdx_q;
        curLen_d = curLen_q;
        hist_d   = hist_q;
        pktLen   = curLen_q + 1'b1;
        if (s_tvalid) begin
            wrPtr_d = wrPtr_q + 1'b1;
            if (s_tlast) begin
                pktIdx_d = pktIdx_q + 1'b1;
                curLen_d = '0;
                for (int m = G_MODS - 1; m > 0; m--) begin
                    hist_d[m] = hist_q[m-1];
                end
                hist_d[0] = pktLen;
            end else begin
                curLen_d = pktLen;
            end
        end
    end

    // Capture counters update on the same edge that writes the word, so a
    // reset in the middle of a packet simply forgets the partial count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wrPtr_q  <= '0;
            pktIdx_q <= '0;
            curLen_q <= '0;
            hist_q   <= '0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            pktIdx_q <= pktIdx_d;
            curLen_q <= curLen_d;
            hist_q   <= hist_d;
        end
    end

    logic                     ramRdEn;
    logic [G_ADDR_WIDTH-1:0]  ramRdAddr;
    logic [G_DW_WIRE_MEM-1:0] ramRdData;

    capture_ram #(
        .DATA_W (G_DW_WIRE_MEM),
        .ADDR_W (G_ADDR_WIDTH)
    ) u_captureRam (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .wrEn_i   (s_tvalid),
        .wrAddr_i (wrPtr_q),
        .wrData_i ({pktIdx_q, s_tdata}),
        .rdEn_i   (ramRdEn),
        .rdAddr_i (ramRdAddr),
        .rdData_o (ramRdData)
    );

    logic [G_INDX_WIDTH-1:0] wordAddr;
    logic                    ramHit;
    logic                    statHit;
    logic [31:0]             statVal;
    logic                    unusedAddrBits;

    assign unusedAddrBits = ^s_axil_araddr[1:0];
    assign wordAddr  = {s_axil_araddr[G_INDX_WIDTH-1:2], 2'b00};
    assign ramHit    = (wordAddr >> (G_ADDR_WIDTH + 3)) == '0;
    assign ramRdAddr = s_axil_araddr[G_ADDR_WIDTH+2:3];

    // Status-register decode. Anything that is neither a RAM slot nor one
    // of these words is answered with SLVERR and zero data.
    always_comb begin
        statHit = 1'b0;
        statVal = '0;
        if (wordAddr == G_INDX_WIDTH'(STAT_BASE + OFF_WR_PTR)) begin
            statHit = 1'b1;
            statVal = 32'(wrPtr_q);
        end
        if (wordAddr == G_INDX_WIDTH'(STAT_BASE + OFF_PKT_IDX)) begin
            statHit = 1'b1;
            statVal = 32'(pktIdx_q);
        end
        if (wordAddr == G_INDX_WIDTH'(STAT_BASE + OFF_CUR_LEN)) begin
            statHit = 1'b1;
            statVal = 32'(curLen_q);
        end
        for (int m = 0; m < G_MODS; m++) begin
            if (wordAddr == G_INDX_WIDTH'(STAT_BASE + OFF_HIST + 4 * m)) begin
                statHit = 1'b1;
                statVal = 32'(hist_q[m]);
            end
        end
    end

    rd_state_e   rdState_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [1:0]  rresp_q;
    logic [31:0] statData_q;
    logic        useRam_q;
    logic        idxSel_q;

    assign ramRdEn = s_axil_arvalid && arready_q && ramHit;

    // Read channel: accept an address while idle, present the response on
    // the following cycle and hold it until the master takes it. arready is
    // low for the whole time a response is outstanding, giving one read per
    // two cycles when both sides are always ready. The RAM word itself is
    // captured by the RAM's own read register on the accept edge; status
    // words are snapshotted here on that same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdState_q  <= RD_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            statData_q <= '0;
            useRam_q   <= 1'b0;
            idxSel_q   <= 1'b0;
        end else begin
            case (rdState_q)
                RD_IDLE: begin
                    if (s_axil_arvalid) begin
                        rdState_q  <= RD_RESP;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        useRam_q   <= ramHit;
                        idxSel_q   <= s_axil_araddr[2];
                        statData_q <= statVal;
                        rresp_q    <= (ramHit || statHit) ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                RD_RESP: begin
                    if (s_axil_rready) begin
                        rdState_q <= RD_IDLE;
                        arready_q <= 1'b1;
                        rvalid_q  <= 1'b0;
                    end
                end
                default: begin
                    rdState_q <= RD_IDLE;
                end
            endcase
        end
    end

    // Pick the half of the captured RAM entry that was addressed, or the
    // snapshotted status word. Every source here is a register.
    always_comb begin
        s_axil_rdata = statData_q;
        if (useRam_q) begin
            s_axil_rdata = idxSel_q ? 32'(ramRdData[G_DW_WIRE_MEM-1:DW])
                                    : 32'(ramRdData[DW-1:0]);
        end
    end

    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;

endmodule

// File: tb/tb_procedural_ip.sv
// Self-checking bench for procedural_ip. A behavioural model of the capture
// RAM and counters supplies expected read responses, which are queued when a
// read is issued and compared when the DUT presents rvalid.
module tb_procedural_ip;

    logic        clock;
    logic        reset;
    logic        sTvalid;
    logic        sTlast;
    logic [31:0] sTdata;
    logic        arvalid;
    logic [9:0]  araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] mData [32];
    logic [9:0]  mIdx [32];
    bit          mValid [32];
    int          mWrPtr;
    int          mPkt;
    int          mCur;
    int          mHist [4];

    logic [33:0] expQ [$];
    string       tagQ [$];

    procedural_ip dut (
        .i_clk          (clock),
        .i_rst          (reset),
        .s_tvalid       (sTvalid),
        .s_tlast        (sTlast),
        .s_tdata        (sTdata),
        .s_axil_arvalid (arvalid),
        .s_axil_araddr  (araddr),
        .s_axil_arready (arready),
        .s_axil_rvalid  (rvalid),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rready  (rready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case some handshake never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [33:0] observed,
                               input logic [33:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            mData[i]  = '0;
            mIdx[i]   = '0;
            mValid[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) mHist[i] = 0;
        mWrPtr = 0;
        mPkt   = 0;
        mCur   = 0;
        expQ.delete();
        tagQ.delete();
    endtask

    task automatic modelWrite(input logic [31:0] data, input bit last);
        mData[mWrPtr]  = data;
        mIdx[mWrPtr]   = 10'(mPkt);
        mValid[mWrPtr] = 1'b1;
        mWrPtr = (mWrPtr + 1) % 32;
        if (last) begin
            for (int i = 3; i > 0; i--) mHist[i] = mHist[i-1];
            mHist[0] = mCur + 1;
            mCur = 0;
            mPkt = (mPkt + 1) % 1024;
        end else begin
            mCur = mCur + 1;
        end
    endtask

    function automatic logic [33:0] expRead(input logic [9:0] addr);
        int w;
        int k;
        w = int'(addr) & 'h3FC;
        if (w < 256) begin
            k = w / 8;
            if (!mValid[k]) return 34'h0;
            if ((w % 8) == 0) return {2'b00, mData[k]};
            return {2'b00, 22'h0, mIdx[k]};
        end
        if (w == 'h100) return {2'b00, 32'(mWrPtr)};
        if (w == 'h104) return {2'b00, 32'(mPkt)};
        if (w == 'h108) return {2'b00, 32'(mCur)};
        if (w >= 'h10C && w <= 'h118) return {2'b00, 32'(mHist[(w - 'h10C) / 4])};
        return {2'b10, 32'h0};
    endfunction

    task automatic doReset();
        @(negedge clock);
        reset   = 1'b1;
        sTvalid = 1'b0;
        sTlast  = 1'b0;
        sTdata  = '0;
        arvalid = 1'b0;
        araddr  = '0;
        rready  = 1'b0;
        modelReset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] data, input bit last);
        @(negedge clock);
        sTvalid = 1'b1;
        sTdata  = data;
        sTlast  = last;
        @(posedge clock);
        modelWrite(data, last);
    endtask

    task automatic streamIdle();
        @(negedge clock);
        sTvalid = 1'b0;
        sTlast  = 1'b0;
    endtask

    // Called at a negedge; waits (bounded) for rvalid and scores the
    // oldest queued expectation against the response.
    task automatic waitResponse();
        bit          got;
        logic [33:0] e;
        string       t;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (rvalid) got = 1'b1;
            else @(negedge clock);
        end
        e = expQ.pop_front();
        t = tagQ.pop_front();
        if (!got) checkOutput({t, "RvalidTimeout"}, 34'(rvalid), 34'd1);
        else checkOutput(t, {rresp, rdata}, e);
    endtask

    task automatic issueRead(input logic [9:0] addr, input string tag,
                             input logic [33:0] expected);
        bit hs;
        expQ.push_back(expected);
        tagQ.push_back(tag);
        @(negedge clock);
        arvalid = 1'b1;
        araddr  = addr;
        rready  = 1'b1;
        hs = 1'b0;
        for (int c = 0; c < 20 && !hs; c++) begin
            if (arready) hs = 1'b1;
            else @(negedge clock);
        end
        if (!hs) checkOutput({tag, "ArreadyTimeout"}, 34'(arready), 34'd1);
        @(negedge clock);
        arvalid = 1'b0;
        waitResponse();
    endtask

    task automatic doRead(input logic [9:0] addr, input string tag);
        issueRead(addr, tag, expRead(addr));
    endtask

    // Streams addresses 0, 8, ..., 248 with arvalid and rready held high and
    // checks both the data order and the two-cycle spacing of responses.
    task automatic backToBack();
        int          issued;
        int          received;
        int          lastCyc;
        logic [33:0] e;
        string       t;
        issued   = 0;
        received = 0;
        lastCyc  = -1;
        @(negedge clock);
        rready = 1'b1;
        for (int cyc = 0; cyc < 200 && received < 32; cyc++) begin
            if (cyc > 0) @(negedge clock);
            if (rvalid) begin
                if (expQ.size() == 0) begin
                    checkOutput("b2bUnexpectedRvalid", 34'd1, 34'd0);
                end else begin
                    e = expQ.pop_front();
                    t = tagQ.pop_front();
                    checkOutput(t, {rresp, rdata}, e);
                end
                if (lastCyc >= 0) checkOutput("b2bGap", 34'(cyc - lastCyc), 34'd2);
                lastCyc = cyc;
                received++;
            end
            if (issued < 32) begin
                araddr  = 10'(issued * 8);
                arvalid = 1'b1;
            end else begin
                arvalid = 1'b0;
            end
            if (arready && issued < 32) begin
                expQ.push_back(expRead(10'(issued * 8)));
                tagQ.push_back($sformatf("b2bEntry%0d", issued));
                issued++;
            end
        end
        arvalid = 1'b0;
        checkOutput("b2bCount", 34'(received), 34'd32);
    endtask

    // Issues a read with rready low and leaves the response pending.
    task automatic startPendingRead(input logic [9:0] addr);
        bit hs;
        @(negedge clock);
        arvalid = 1'b1;
        araddr  = addr;
        rready  = 1'b0;
        hs = 1'b0;
        for (int c = 0; c < 20 && !hs; c++) begin
            if (arready) hs = 1'b1;
            else @(negedge clock);
        end
        if (!hs) checkOutput("pendArreadyTimeout", 34'(arready), 34'd1);
        @(negedge clock);
        arvalid = 1'b0;
    endtask

    task automatic holdTest();
        logic [33:0] e;
        e = expRead(10'h18);
        startPendingRead(10'h18);
        for (int i = 0; i < 3; i++) begin
            checkOutput("holdRvalid", 34'(rvalid), 34'd1);
            checkOutput("holdArready", 34'(arready), 34'd0);
            checkOutput("holdData", {rresp, rdata}, e);
            @(negedge clock);
        end
        rready = 1'b1;
        @(negedge clock);
        checkOutput("releaseRvalid", 34'(rvalid), 34'd0);
        checkOutput("releaseArready", 34'(arready), 34'd1);
        rready = 1'b0;
    endtask

    // Write and read the same entry in one cycle: the read sees old data.
    task automatic sameCycleRead(input logic [31:0] data);
        logic [9:0] addr;
        addr = 10'(mWrPtr * 8);
        expQ.push_back(expRead(addr));
        tagQ.push_back("readFirst");
        @(negedge clock);
        sTvalid = 1'b1;
        sTdata  = data;
        sTlast  = 1'b0;
        arvalid = 1'b1;
        araddr  = addr;
        rready  = 1'b1;
        checkOutput("readFirstArready", 34'(arready), 34'd1);
        @(posedge clock);
        modelWrite(data, 1'b0);
        @(negedge clock);
        sTvalid = 1'b0;
        arvalid = 1'b0;
        waitResponse();
        doRead(addr, "afterWrite");
    endtask

    initial begin
        reset   = 1'b1;
        sTvalid = 1'b0;
        sTlast  = 1'b0;
        sTdata  = '0;
        arvalid = 1'b0;
        araddr  = '0;
        rready  = 1'b0;
        modelReset();
        repeat (3) @(negedge clock);
        reset = 1'b0;

        checkOutput("rstArready", 34'(arready), 34'd1);
        checkOutput("rstRvalid", 34'(rvalid), 34'd0);
        checkOutput("rstRdataResp", {rresp, rdata}, 34'h0);
        issueRead(10'h100, "rstWrPtr", 34'h0);
        issueRead(10'h104, "rstPktIdx", 34'h0);
        issueRead(10'h000, "rstEntry0", 34'h0);

        $display("[TB] three-word packet");
        applyStimulus(32'd5, 1'b0);
        applyStimulus(32'hFFFF_FFF9, 1'b0);
        applyStimulus(32'd12, 1'b1);
        streamIdle();
        issueRead(10'h000, "pkt3Data0", {2'b00, 32'd5});
        issueRead(10'h008, "pkt3Data1", {2'b00, 32'hFFFF_FFF9});
        issueRead(10'h010, "pkt3Data2", {2'b00, 32'd12});
        issueRead(10'h014, "pkt3Idx2", 34'h0);
        issueRead(10'h100, "pkt3WrPtr", {2'b00, 32'd3});
        issueRead(10'h104, "pkt3PktIdx", {2'b00, 32'd1});
        issueRead(10'h10C, "pkt3Hist0", {2'b00, 32'd3});
        issueRead(10'h108, "pkt3CurLen", 34'h0);

        $display("[TB] wrap-around packet");
        doReset();
        for (int i = 0; i < 40; i++) applyStimulus(32'(i), i == 39);
        streamIdle();
        issueRead(10'h000, "wrapEntry0", {2'b00, 32'd32});
        issueRead(10'h038, "wrapEntry7", {2'b00, 32'd39});
        issueRead(10'h040, "wrapEntry8", {2'b00, 32'd8});
        issueRead(10'h0F8, "wrapEntry31", {2'b00, 32'd31});
        issueRead(10'h100, "wrapWrPtr", {2'b00, 32'd8});
        backToBack();
        holdTest();

        $display("[TB] length history");
        doReset();
        for (int len = 1; len <= 5; len++) begin
            for (int w = 0; w < len; w++) applyStimulus(32'(len * 16 + w), w == len - 1);
        end
        streamIdle();
        issueRead(10'h10C, "hist0", {2'b00, 32'd5});
        issueRead(10'h110, "hist1", {2'b00, 32'd4});
        issueRead(10'h114, "hist2", {2'b00, 32'd3});
        issueRead(10'h118, "hist3", {2'b00, 32'd2});
        issueRead(10'h104, "histPktIdx", {2'b00, 32'd5});
        issueRead(10'h074, "histIdx14", {2'b00, 32'd4});
        issueRead(10'h100, "histWrPtr", {2'b00, 32'd15});

        sameCycleRead(32'hABCD_0123);
        issueRead(10'h07C, "newIdx15", {2'b00, 32'd5});
        doRead(10'h102, "lowBitsIgnored");
        doRead(10'h108, "curLenOpen");

        issueRead(10'h200, "slvErr200", {2'b10, 32'h0});
        issueRead(10'h11C, "slvErr11C", {2'b10, 32'h0});
        issueRead(10'h3FC, "slvErr3FC", {2'b10, 32'h0});

        $display("[TB] reset mid-packet");
        applyStimulus(32'd100, 1'b0);
        applyStimulus(32'd101, 1'b0);
        streamIdle();
        startPendingRead(10'h108);
        checkOutput("pendRvalid", 34'(rvalid), 34'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midRstRvalid", 34'(rvalid), 34'd0);
        checkOutput("midRstArready", 34'(arready), 34'd1);
        checkOutput("midRstRdata", {rresp, rdata}, 34'h0);
        modelReset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        issueRead(10'h100, "midRstWrPtr", 34'h0);
        issueRead(10'h104, "midRstPktIdx", 34'h0);
        issueRead(10'h108, "midRstCurLen", 34'h0);
        issueRead(10'h10C, "midRstHist0", 34'h0);
        issueRead(10'h000, "midRstEntry0", 34'h0);

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
